// File: rtl/inst_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_enc_pkg
//  Description : Shared formats, opcodes, widths and the immediate checker
//                used by the instruction encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_enc_pkg;

   localparam int INST_W = 32;
   localparam int OPC_W  = 7;
   localparam int REG_W  = 5;
   localparam int F3_W   = 3;
   localparam int F7_W   = 7;
   localparam int IMM_W  = 32;
   localparam int CNT_W  = 16;
   localparam int FMT_W  = 3;

   typedef enum logic [FMT_W-1:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
   localparam logic [OPC_W-1:0] OP_REG    = 7'h33;

   // True when the immediate cannot be represented exactly by the format.
   function automatic logic imm_illegal(input logic [FMT_W-1:0] fmt,
                                        input logic [IMM_W-1:0] imm);
      logic bad;
      bad = 1'b0;
      case (fmt)
         FMT_I, FMT_S: bad = (imm != {{20{imm[11]}}, imm[11:0]});
         FMT_B:        bad = imm[0] || (imm != {{19{imm[12]}}, imm[12:0]});
         FMT_J:        bad = imm[0] || (imm != {{11{imm[20]}}, imm[20:0]});
         FMT_U:        bad = (imm[11:0] != 12'd0);
         default:      bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/inst_enc_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_enc_if
//  Description : Field-input, address-load and memory-write bundle of the
//                instruction encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_enc_if #(parameter int ADDR_W = 32);
   import inst_enc_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [FMT_W-1:0]    in_fmt;
   logic [OPC_W-1:0]    opcode;
   logic [REG_W-1:0]    rd;
   logic [REG_W-1:0]    rs1;
   logic [REG_W-1:0]    rs2;
   logic [F3_W-1:0]     funct3;
   logic [F7_W-1:0]     funct7;
   logic [IMM_W-1:0]    imm;
   logic                base_load;
   logic [ADDR_W-1:0]   base_addr;
   logic                busy;
   logic                mem_we;
   logic                mem_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic [INST_W-1:0]   mem_wdata;
   logic [CNT_W-1:0]    inst_count;
   logic                enc_err;

   modport master (
      output in_valid, in_fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
             base_load, base_addr, mem_ready,
      input  in_ready, busy, mem_we, mem_addr, mem_wdata, inst_count, enc_err
   );

   modport slave (
      input  in_valid, in_fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
             base_load, base_addr, mem_ready,
      output in_ready, busy, mem_we, mem_addr, mem_wdata, inst_count, enc_err
   );

endinterface
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fifo
//  Description : Synchronous FIFO with full/empty flags, head shown on rdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign full  = (r_count == (AW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign w_wr  = push && !full;
   assign w_rd  = pop && !empty;
   assign rdata = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by r_count.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/inst_enc.sv
`default_nettype none
// ============================================================================
//  Module      : inst_enc
//  Description : Packs RISC-V fields into words, queues and writes them to
//                sequential memory addresses. INST_ENC_CHECK_EN enables the
//                immediate legality check and enc_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_enc
   import inst_enc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   inst_enc_if.slave  bus
);

   logic [INST_W-1:0] w_word;
   logic [INST_W-1:0] w_head;
   logic [IMM_W-1:0]  w_imm;
   logic              w_accept;
   logic              w_illegal;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_cnt;

   assign w_imm = bus.imm;

   always_comb begin
      w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      case (bus.in_fmt)
         FMT_I: w_word = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         FMT_S: w_word = {w_imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                          w_imm[4:0], bus.opcode};
         FMT_B: w_word = {w_imm[12], w_imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                          w_imm[4:1], w_imm[11], bus.opcode};
         FMT_U: w_word = {w_imm[31:12], bus.rd, bus.opcode};
         FMT_J: w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                          bus.rd, bus.opcode};
         default: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd,
                            bus.opcode};
      endcase
   end

   // A pending address load blocks intake so it can never race a push.
   assign bus.in_ready = !w_full && !bus.base_load;
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_push       = w_accept && !w_illegal;
   assign w_pop        = !w_empty && bus.mem_ready;

`ifdef INST_ENC_CHECK_EN
   logic r_enc_err;

   assign w_illegal = imm_illegal(bus.in_fmt, w_imm);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_enc_err <= 1'b0;
      else        r_enc_err <= w_accept && w_illegal;
   end

   assign bus.enc_err = r_enc_err;
`else
   assign w_illegal   = 1'b0;
   assign bus.enc_err = 1'b0;
`endif

   inst_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INST_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (w_word),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_cnt  <= '0;
      end else if (w_pop) begin
         r_addr <= r_addr + ADDR_W'(4);
         r_cnt  <= r_cnt + CNT_W'(1);
      end else if (bus.base_load && w_empty && !w_push) begin
         r_addr <= bus.base_addr;
         r_cnt  <= '0;
      end
   end

   assign bus.mem_we     = !w_empty;
   assign bus.busy       = !w_empty;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = w_head;
   assign bus.inst_count = r_cnt;

endmodule
`default_nettype wire
